// File: rtl/mux_n_pipe_if.sv
// Handshake/data bundle for mux_n_pipe.
// The slave modport is the selector's view: channel data, requests, select,
// mode and downstream ready come in; per-channel ready and the registered
// output word go out. The master modport is the mirror used by whoever
// drives the channels and consumes the output.
interface mux_n_pipe_if #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic [N*W-1:0]  din;
  logic [N-1:0]    din_valid;
  logic [N-1:0]    din_ready;
  logic [SELW-1:0] sel;
  logic            mode;
  logic [W-1:0]    dout;
  logic [SELW-1:0] dout_chan;
  logic            dout_valid;
  logic            dout_ready;

  modport slave (
    input  din, din_valid, sel, mode, dout_ready,
    output din_ready, dout, dout_chan, dout_valid
  );

  modport master (
    output din, din_valid, sel, mode, dout_ready,
    input  din_ready, dout, dout_chan, dout_valid
  );
endinterface

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: registered N-to-1 W-bit selector with valid/ready on every
// channel and on the output, backed by a one-entry output register.
// Selection is either explicit (sel) or round-robin among requesting
// channels starting at an internal pointer.
// Optional feature macro: MUX_N_PIPE_RR_EN. When undefined, mode is ignored
// (treated as explicit select) and the round-robin pointer does not exist.
module mux_n_pipe #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic         clk,
  input  logic         rst,
  mux_n_pipe_if.slave  bus
);

  // Output register and its next state.
  logic [W-1:0]    dout_q, dout_d;
  logic [SELW-1:0] chan_q, chan_d;
  logic            valid_q, valid_d;

  // Grant path.
  logic            accept;
  logic            mode_eff;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic            xfer;

  // Explicit-select grant.
  logic [N-1:0]    sel_hit;
  logic            exp_valid;

  // Per-channel views.
  logic [W-1:0]    slice [N];
  logic [N-1:0]    hot;
  logic [N-1:0]    ready_vec;
  logic [W-1:0]    sel_data;

`ifdef MUX_N_PIPE_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            rr_valid;
  logic [SELW-1:0] rr_grant;
`endif

  // The register can take a new word when empty or when the held word is
  // leaving this cycle; this lets load and drain overlap without a bubble.
  assign accept = !valid_q || bus.dout_ready;

`ifdef MUX_N_PIPE_RR_EN
  assign mode_eff = bus.mode;
`else
  assign mode_eff = 1'b0;
`endif

  // Per-channel decode: data slice, explicit-select hit, one-hot grant and
  // the resulting ready. A sel value at or beyond N matches no channel, so
  // it simply yields no grant.
  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    assign slice[gi]     = bus.din[gi*W +: W];
    assign sel_hit[gi]   = (bus.sel == SELW'(gi)) && bus.din_valid[gi];
    assign hot[gi]       = grant_valid && (grant == SELW'(gi));
    assign ready_vec[gi] = hot[gi] && accept && !rst;
  end

  assign exp_valid = |sel_hit;

`ifdef MUX_N_PIPE_RR_EN
  // Round-robin scan: walk from ptr upward with wrap; scanning the offsets
  // from the far end back toward ptr lets the closest requester win last.
  always_comb begin
    int idx;
    rr_valid = 1'b0;
    rr_grant = '0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (bus.din_valid[idx]) begin
        rr_valid = 1'b1;
        rr_grant = SELW'(idx);
      end
    end
  end

  // Grant source chosen by mode; the mode change applies to this cycle's
  // evaluation only, nothing about it is latched.
  always_comb begin
    grant_valid = exp_valid;
    grant       = bus.sel;
    if (mode_eff) begin
      grant_valid = rr_valid;
      grant       = rr_grant;
    end
  end
`else
  // Explicit select only.
  always_comb begin
    grant_valid = exp_valid;
    grant       = bus.sel;
  end
`endif

  // Data mux as an AND-OR over the one-hot grant so an out-of-range grant
  // index can never address a nonexistent slice.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (slice[i] & {W{hot[i]}});
    end
  end

  // A grant is only ever issued to a requesting channel, so any ready bit
  // high means a transfer.
  assign xfer = |(ready_vec & bus.din_valid);

  // Output register next state: load on transfer, otherwise empty when the
  // consumer takes the word; data and channel hold their last values.
  always_comb begin
    dout_d  = dout_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (xfer) begin
      dout_d  = sel_data;
      chan_d  = grant;
      valid_d = 1'b1;
    end else if (bus.dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register update; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

`ifdef MUX_N_PIPE_RR_EN
  // Pointer advances past the winner only on a round-robin transfer, so an
  // explicit-select phase leaves the rotation where it was.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode_eff) begin
      ptr_d = (int'(grant) == N - 1) ? '0 : grant + SELW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign bus.din_ready  = ready_vec;
  assign bus.dout       = dout_q;
  assign bus.dout_chan  = chan_q;
  assign bus.dout_valid = valid_q;

endmodule
